// File: rtl/riscv_defines.sv
// rtl/riscv_defines.sv - shared types for the branch resolver
package riscv_defines;

  // One in-flight prediction as recorded by fetch.
  typedef struct packed {
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_target;
  } bp_entry_t;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_RECOVER = 1'b1
  } br_state_e;

endpackage

// File: rtl/branch_pred_fifo.sv
// rtl/branch_pred_fifo.sv - in-flight prediction storage, async read of the head entry
module branch_pred_fifo
  import riscv_defines::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      wr_en,
  input  bp_entry_t wr_data,
  input  logic      rd_en,
  input  logic      clear,
  output bp_entry_t head,
  output logic      empty,
  output logic      full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  bp_entry_t   mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;

  // Extra MSB on each pointer separates full from empty when the index bits match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_en && !full)  wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_en && !empty) rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !full && !clear) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/branch_resolver.sv
// rtl/branch_resolver.sv - matches resolved control flow against fetch predictions and redirects on mispredict
module branch_resolver
  import riscv_defines::*;
#(
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push_valid,
  input  logic [31:0]          push_pc,
  input  logic                 push_pred_taken,
  input  logic [31:0]          push_pred_target,
  output logic                 full,
  input  logic                 resolve_valid,
  input  logic                 resolve_is_branch,
  input  logic                 resolve_taken,
  input  logic [31:0]          resolve_target,
  output logic                 mispredict,
  output logic [31:0]          redirect_pc,
  output logic                 upd_valid,
  output logic [31:0]          upd_pc,
  output logic                 upd_taken,
  output logic [CNT_WIDTH-1:0] branch_cnt,
  output logic [CNT_WIDTH-1:0] mispredict_cnt,
  output logic                 underflow
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  br_state_e            state_q, state_d;
  logic                 mispredict_q, mispredict_d;
  logic [31:0]          redirect_pc_q, redirect_pc_d;
  logic                 upd_valid_q, upd_valid_d;
  logic [31:0]          upd_pc_q, upd_pc_d;
  logic                 upd_taken_q, upd_taken_d;
  logic [CNT_WIDTH-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_WIDTH-1:0] mispredict_cnt_q, mispredict_cnt_d;
  logic                 underflow_q, underflow_d;

  bp_entry_t push_entry;
  bp_entry_t head;
  logic      fifo_empty, fifo_full;
  logic      in_run, do_pop, do_push, mis_now;

  assign push_entry = '{pc: push_pc, pred_taken: push_pred_taken, pred_target: push_pred_target};

  branch_pred_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (do_push),
    .wr_data (push_entry),
    .rd_en   (do_pop),
    .clear   (mis_now),
    .head    (head),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  always_comb begin
    in_run  = (state_q == ST_RUN);
    do_pop  = resolve_valid && !fifo_empty && in_run;
    mis_now = do_pop && ((head.pred_taken != resolve_taken) ||
              (resolve_taken && head.pred_target != resolve_target));
    // A mispredict flushes everything younger, including this cycle's fetch.
    do_push = push_valid && !fifo_full && in_run && !mis_now;
  end

  always_comb begin
    state_d          = state_q;
    mispredict_d     = mis_now;
    redirect_pc_d    = redirect_pc_q;
    upd_valid_d      = do_pop && resolve_is_branch;
    upd_pc_d         = upd_pc_q;
    upd_taken_d      = upd_taken_q;
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;
    underflow_d      = underflow_q || (resolve_valid && fifo_empty && in_run);

    case (state_q)
      ST_RUN:     if (mis_now) state_d = ST_RECOVER;
      ST_RECOVER: state_d = ST_RUN;
      default:    state_d = ST_RUN;
    endcase

    if (mis_now) begin
      redirect_pc_d    = resolve_taken ? resolve_target : head.pc + 32'd4;
      mispredict_cnt_d = mispredict_cnt_q + CNT_ONE;
    end
    if (do_pop && resolve_is_branch) begin
      upd_pc_d     = head.pc;
      upd_taken_d  = resolve_taken;
      branch_cnt_d = branch_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_RUN;
      mispredict_q     <= 1'b0;
      redirect_pc_q    <= '0;
      upd_valid_q      <= 1'b0;
      upd_pc_q         <= '0;
      upd_taken_q      <= 1'b0;
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
      underflow_q      <= 1'b0;
    end else begin
      state_q          <= state_d;
      mispredict_q     <= mispredict_d;
      redirect_pc_q    <= redirect_pc_d;
      upd_valid_q      <= upd_valid_d;
      upd_pc_q         <= upd_pc_d;
      upd_taken_q      <= upd_taken_d;
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
      underflow_q      <= underflow_d;
    end
  end

  assign full           = fifo_full;
  assign mispredict     = mispredict_q;
  assign redirect_pc    = redirect_pc_q;
  assign upd_valid      = upd_valid_q;
  assign upd_pc         = upd_pc_q;
  assign upd_taken      = upd_taken_q;
  assign branch_cnt     = branch_cnt_q;
  assign mispredict_cnt = mispredict_cnt_q;
  assign underflow      = underflow_q;

endmodule

// File: tb/tb_branch_resolver.sv
// tb/tb_branch_resolver.sv - scoreboard bench for branch_resolver
module tb_branch_resolver;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        push_valid = 1'b0;
  logic [31:0] push_pc = '0;
  logic        push_pred_taken = 1'b0;
  logic [31:0] push_pred_target = '0;
  logic        full;
  logic        resolve_valid = 1'b0;
  logic        resolve_is_branch = 1'b0;
  logic        resolve_taken = 1'b0;
  logic [31:0] resolve_target = '0;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] branch_cnt;
  logic [31:0] mispredict_cnt;
  logic        underflow;

  branch_resolver #(.DEPTH(DEPTH), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .push_valid(push_valid), .push_pc(push_pc), .push_pred_taken(push_pred_taken),
    .push_pred_target(push_pred_target), .full(full),
    .resolve_valid(resolve_valid), .resolve_is_branch(resolve_is_branch),
    .resolve_taken(resolve_taken), .resolve_target(resolve_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        pt;
    logic [31:0] tg;
  } ment_t;

  typedef struct {
    logic        mis;
    logic [31:0] rpc;
    logic        uv;
    logic [31:0] upc;
    logic        ut;
  } exp_t;

  ment_t mq[$];
  exp_t  sb[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    exp_bcnt = 0;
  int    exp_mcnt = 0;
  logic  exp_uf = 1'b0;
  logic  m_recover = 1'b0;
  exp_t  e;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model updated as stimulus is driven; resolves queue their expected outputs.
  task automatic step(input logic pv, input logic [31:0] ppc, input logic ppt, input logic [31:0] ptg,
                      input logic rv, input logic rib, input logic rtk, input logic [31:0] rtg);
    exp_t  ex;
    ment_t h;
    logic  mis;
    logic  can_push;
    ex  = '{mis: 1'b0, rpc: 32'd0, uv: 1'b0, upc: 32'd0, ut: 1'b0};
    mis = 1'b0;
    if (!m_recover) begin
      can_push = (mq.size() < DEPTH);
      if (rv) begin
        if (mq.size() == 0) exp_uf = 1'b1;
        else begin
          h      = mq.pop_front();
          mis    = (h.pt != rtk) || (rtk && h.tg != rtg);
          ex.mis = mis;
          ex.rpc = rtk ? rtg : h.pc + 32'd4;
          ex.uv  = rib;
          ex.upc = h.pc;
          ex.ut  = rtk;
          if (rib) exp_bcnt++;
          if (mis) exp_mcnt++;
        end
      end
      if (mis) mq.delete();
      else if (pv && can_push) mq.push_back('{pc: ppc, pt: ppt, tg: ptg});
    end
    m_recover = mis;
    if (rv) sb.push_back(ex);
    push_valid = pv; push_pc = ppc; push_pred_taken = ppt; push_pred_target = ptg;
    resolve_valid = rv; resolve_is_branch = rib; resolve_taken = rtk; resolve_target = rtg;
    tick();
    push_valid = 1'b0;
    resolve_valid = 1'b0;
  endtask

  task automatic push(input logic [31:0] pc, input logic pt, input logic [31:0] tg);
    step(1'b1, pc, pt, tg, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic resolve(input logic rib, input logic rtk, input logic [31:0] rtg);
    step(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, rib, rtk, rtg);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    n_cmp++;
    if ({full, mispredict, redirect_pc, upd_valid, upd_pc, upd_taken, branch_cnt, mispredict_cnt, underflow} !== '0) begin
      n_bad++;
      $display("FAIL reset_state: full=%b mis=%b rpc=%h uv=%b upc=%h ut=%b bc=%0d mc=%0d uf=%b, expected all zero",
               full, mispredict, redirect_pc, upd_valid, upd_pc, upd_taken, branch_cnt, mispredict_cnt, underflow);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_correct_predict();
    push(32'h100, 1'b0, 32'h0);
    resolve(1'b1, 1'b0, 32'h0);
    e = sb.pop_front(); n_cmp++;
    if (mispredict !== e.mis || upd_valid !== e.uv || (e.uv && (upd_pc !== e.upc || upd_taken !== e.ut))) begin
      n_bad++;
      $display("FAIL correct_predict: mis=%b uv=%b upc=%h ut=%b, expected mis=%b uv=%b upc=%h ut=%b",
               mispredict, upd_valid, upd_pc, upd_taken, e.mis, e.uv, e.upc, e.ut);
    end
    n_cmp++;
    if (branch_cnt !== 32'(exp_bcnt)) begin
      n_bad++; $display("FAIL branch_cnt_1: got %0d expected %0d", branch_cnt, exp_bcnt);
    end
  endtask

  task automatic test_mispredict_nt();
    push(32'h200, 1'b0, 32'h0);
    push(32'h204, 1'b0, 32'h0);
    resolve(1'b1, 1'b1, 32'h300);
    e = sb.pop_front(); n_cmp++;
    if (mispredict !== e.mis || (e.mis && redirect_pc !== e.rpc) || upd_valid !== e.uv) begin
      n_bad++;
      $display("FAIL mispredict_taken: mis=%b rpc=%h uv=%b, expected mis=%b rpc=%h uv=%b",
               mispredict, redirect_pc, upd_valid, e.mis, e.rpc, e.uv);
    end
    push(32'h208, 1'b0, 32'h0);
    n_cmp++;
    if (mispredict !== 1'b0 || mispredict_cnt !== 32'(exp_mcnt)) begin
      n_bad++;
      $display("FAIL mispredict_pulse: mis=%b mcnt=%0d, expected mis=0 mcnt=%0d", mispredict, mispredict_cnt, exp_mcnt);
    end
    push(32'h20C, 1'b0, 32'h0);
    resolve(1'b1, 1'b0, 32'h0);
    e = sb.pop_front(); n_cmp++;
    if (mispredict !== e.mis || upd_valid !== e.uv || (e.uv && upd_pc !== e.upc)) begin
      n_bad++;
      $display("FAIL flush_and_recover_drop: mis=%b uv=%b upc=%h, expected mis=%b uv=%b upc=%h",
               mispredict, upd_valid, upd_pc, e.mis, e.uv, e.upc);
    end
  endtask

  task automatic test_target_mismatch();
    push(32'h400, 1'b1, 32'h500);
    resolve(1'b1, 1'b1, 32'h508);
    e = sb.pop_front(); n_cmp++;
    if (mispredict !== e.mis || (e.mis && redirect_pc !== e.rpc) || upd_pc !== e.upc || upd_taken !== e.ut) begin
      n_bad++;
      $display("FAIL target_mismatch: mis=%b rpc=%h upc=%h ut=%b, expected mis=%b rpc=%h upc=%h ut=%b",
               mispredict, redirect_pc, upd_pc, upd_taken, e.mis, e.rpc, e.upc, e.ut);
    end
    n_cmp++;
    if (mispredict_cnt !== 32'(exp_mcnt)) begin
      n_bad++; $display("FAIL mispredict_cnt: got %0d expected %0d", mispredict_cnt, exp_mcnt);
    end
    step(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic test_full();
    for (int i = 0; i < DEPTH; i++) push(32'h600 + 32'(4 * i), 1'b0, 32'h0);
    n_cmp++;
    if (full !== 1'b1) begin
      n_bad++; $display("FAIL full_set: got %b expected 1", full);
    end
    step(1'b1, 32'h700, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0);
    n_cmp++;
    if (full !== 1'b0) begin
      n_bad++; $display("FAIL full_after_pop: got %b expected 0", full);
    end
    e = sb.pop_front(); n_cmp++;
    if (mispredict !== e.mis || upd_valid !== e.uv || upd_pc !== e.upc) begin
      n_bad++;
      $display("FAIL full_push_pop: mis=%b uv=%b upc=%h, expected mis=%b uv=%b upc=%h",
               mispredict, upd_valid, upd_pc, e.mis, e.uv, e.upc);
    end
    for (int i = 0; i < DEPTH - 1; i++) begin
      resolve(1'b1, 1'b0, 32'h0);
      e = sb.pop_front(); n_cmp++;
      if (mispredict !== e.mis || upd_valid !== e.uv || upd_pc !== e.upc || underflow !== exp_uf) begin
        n_bad++;
        $display("FAIL drain_%0d: mis=%b uv=%b upc=%h uf=%b, expected mis=%b uv=%b upc=%h uf=%b",
                 i, mispredict, upd_valid, upd_pc, underflow, e.mis, e.uv, e.upc, exp_uf);
      end
    end
  endtask

  task automatic test_underflow();
    resolve(1'b1, 1'b0, 32'h0);
    e = sb.pop_front(); n_cmp++;
    if (underflow !== exp_uf || upd_valid !== e.uv || mispredict !== e.mis) begin
      n_bad++;
      $display("FAIL underflow_set: uf=%b uv=%b mis=%b, expected uf=%b uv=%b mis=%b",
               underflow, upd_valid, mispredict, exp_uf, e.uv, e.mis);
    end
    push(32'h800, 1'b0, 32'h0);
    resolve(1'b1, 1'b0, 32'h0);
    e = sb.pop_front(); n_cmp++;
    if (underflow !== exp_uf || upd_valid !== e.uv || upd_pc !== e.upc || branch_cnt !== 32'(exp_bcnt)) begin
      n_bad++;
      $display("FAIL underflow_sticky: uf=%b uv=%b upc=%h bc=%0d, expected uf=%b uv=%b upc=%h bc=%0d",
               underflow, upd_valid, upd_pc, branch_cnt, exp_uf, e.uv, e.upc, exp_bcnt);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) push(32'h900 + 32'(4 * i), 1'b1, 32'hA00);
    #2;
    rst_n = 1'b0;
    mq.delete(); exp_bcnt = 0; exp_mcnt = 0; exp_uf = 1'b0; m_recover = 1'b0;
    #1;
    n_cmp++;
    if ({full, mispredict, redirect_pc, upd_valid, upd_pc, upd_taken, branch_cnt, mispredict_cnt, underflow} !== '0) begin
      n_bad++;
      $display("FAIL async_reset: full=%b mis=%b rpc=%h uv=%b upc=%h ut=%b bc=%0d mc=%0d uf=%b, expected all zero",
               full, mispredict, redirect_pc, upd_valid, upd_pc, upd_taken, branch_cnt, mispredict_cnt, underflow);
    end
    tick();
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (mispredict !== 1'b0 || upd_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_release_quiet: mis=%b uv=%b, expected 0 0", mispredict, upd_valid);
    end
    resolve(1'b1, 1'b1, 32'hA00);
    e = sb.pop_front(); n_cmp++;
    if (underflow !== exp_uf || upd_valid !== e.uv || mispredict !== e.mis) begin
      n_bad++;
      $display("FAIL reset_flushed: uf=%b uv=%b mis=%b, expected uf=%b uv=%b mis=%b",
               underflow, upd_valid, mispredict, exp_uf, e.uv, e.mis);
    end
  endtask

  initial begin
    test_reset();
    test_correct_predict();
    test_mispredict_nt();
    test_target_mismatch();
    test_full();
    test_underflow();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
